// File: rtl/common_pkg.sv
// common_pkg
// Shared constants and types for the dispatch stage.
//   ROB_IDX_W        : default width of a ROB index
//   PAYLOAD_W        : default width of a decoded-instruction payload
//   dispatch_entry_t : one buffered instruction (payload + branch flag)
//   dispatch_state_e : occupancy of the dispatch buffer
package common_pkg;

  localparam int ROB_IDX_W = 4;
  localparam int PAYLOAD_W = 32;

  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    logic                 is_branch;
  } dispatch_entry_t;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } dispatch_state_e;

endpackage

// File: rtl/dispatch_fifo.sv
// dispatch_fifo
// In-order storage for the dispatch stage: circular buffer with registered
// head/tail pointers and an occupancy count.
// Ports:
//   clk, reset_n : clock and asynchronous active-low reset
//   push         : write push_data at tail (caller guarantees not full)
//   pop          : retire the head entry (caller guarantees not empty)
//   clear        : drop every entry and rewind both pointers; beats push/pop
//   push_data    : entry to write
//   head_data    : entry currently at the head slot
//   state        : EMPTY / PARTIAL / FULL, decoded from the registered count
module dispatch_fifo
  import common_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            push,
  input  logic            pop,
  input  logic            clear,
  input  dispatch_entry_t push_data,
  output dispatch_entry_t head_data,
  output dispatch_state_e state
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  dispatch_entry_t      mem [DEPTH];
  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;
  logic [CNT_W-1:0]     count;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[tail] <= push_data;
        tail      <= tail + PTR_W'(1);
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_data = mem[head];

  always_comb begin
    state = PARTIAL;
    if (count == '0) begin
      state = EMPTY;
    end else if (count == CNT_W'(DEPTH)) begin
      state = FULL;
    end
  end

endmodule

// File: rtl/dispatch_stage.sv
// dispatch_stage
// In-order dispatch buffer between decode and the ROB / reservation stations.
// The oldest buffered instruction is sent to the RS in the same cycle the ROB
// allocates its entry, tagged with the ROB index granted. A mispredict flush
// discards everything buffered.
// Ports:
//   clk, reset_n                      : clock, asynchronous active-low reset
//   dec_valid/dec_ready               : decode handshake
//   dec_payload/dec_is_branch         : incoming decoded instruction
//   rob_full/rob_alloc_id             : ROB availability and granted index
//   rob_dispatch_en                   : allocate a ROB entry this cycle
//   rs_ready/rs_valid                 : RS availability and write strobe
//   rs_payload/rs_is_branch/rs_rob_id : RS write data (head entry + ROB tag)
//   flush                             : branch mispredict, discards the buffer
//   stall_count                       : saturating count of blocked-head cycles
module dispatch_stage #(
  parameter int ROB_IDX_W = common_pkg::ROB_IDX_W,
  parameter int PAYLOAD_W = common_pkg::PAYLOAD_W,
  parameter int BUF_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 dec_valid,
  output logic                 dec_ready,
  input  logic [PAYLOAD_W-1:0] dec_payload,
  input  logic                 dec_is_branch,
  input  logic                 rob_full,
  input  logic [ROB_IDX_W-1:0] rob_alloc_id,
  output logic                 rob_dispatch_en,
  input  logic                 rs_ready,
  output logic                 rs_valid,
  output logic [PAYLOAD_W-1:0] rs_payload,
  output logic                 rs_is_branch,
  output logic [ROB_IDX_W-1:0] rs_rob_id,
  input  logic                 flush,
  output logic [15:0]          stall_count
);

  import common_pkg::*;

  dispatch_entry_t push_data;
  dispatch_entry_t head_data;
  dispatch_state_e state;
  logic            enqueue;
  logic            dispatch;
  logic            has_entry;

  // Ready comes only from registered occupancy, so a FULL buffer refuses a
  // new instruction even when its head leaves in the same cycle.
  assign dec_ready = (state != FULL);
  assign has_entry = (state != EMPTY);

  assign enqueue  = dec_valid & dec_ready & ~flush;
  assign dispatch = has_entry & ~rob_full & rs_ready & ~flush;

  assign push_data.payload   = dec_payload;
  assign push_data.is_branch = dec_is_branch;

  dispatch_fifo #(
    .DEPTH(BUF_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (enqueue),
    .pop       (dispatch),
    .clear     (flush),
    .push_data (push_data),
    .head_data (head_data),
    .state     (state)
  );

  // ROB allocation and RS write are one event; both strobes share one source.
  assign rob_dispatch_en = dispatch;
  assign rs_valid        = dispatch;
  assign rs_payload      = head_data.payload;
  assign rs_is_branch    = head_data.is_branch;
  assign rs_rob_id       = rob_alloc_id;

  // Counts cycles where an instruction waits on ROB/RS; survives flushes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= '0;
    end else if (has_entry && !flush && !dispatch && stall_count != 16'hFFFF) begin
      stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_dispatch_stage.sv
// tb_dispatch_stage
// Self-checking bench for dispatch_stage: directed scenarios followed by a
// randomized phase, all compared against a queue-based model of the buffer.
module tb_dispatch_stage;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_payload;
  logic        dec_is_branch;
  logic        rob_full;
  logic [3:0]  rob_alloc_id;
  logic        rob_dispatch_en;
  logic        rs_ready;
  logic        rs_valid;
  logic [31:0] rs_payload;
  logic        rs_is_branch;
  logic [3:0]  rs_rob_id;
  logic        flush;
  logic [15:0] stall_count;

  typedef struct {
    logic [31:0] payload;
    logic        is_branch;
  } ent_t;

  ent_t        model_q[$];
  int unsigned model_stall;
  int          checks;
  int          errors;

  dispatch_stage #(
    .ROB_IDX_W(4),
    .PAYLOAD_W(32),
    .BUF_DEPTH(DEPTH)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .dec_valid       (dec_valid),
    .dec_ready       (dec_ready),
    .dec_payload     (dec_payload),
    .dec_is_branch   (dec_is_branch),
    .rob_full        (rob_full),
    .rob_alloc_id    (rob_alloc_id),
    .rob_dispatch_en (rob_dispatch_en),
    .rs_ready        (rs_ready),
    .rs_valid        (rs_valid),
    .rs_payload      (rs_payload),
    .rs_is_branch    (rs_is_branch),
    .rs_rob_id       (rs_rob_id),
    .flush           (flush),
    .stall_count     (stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] p, input logic br,
                               input logic rf, input logic [3:0] id, input logic rsr,
                               input logic fl);
    dec_valid     = v;
    dec_payload   = p;
    dec_is_branch = br;
    rob_full      = rf;
    rob_alloc_id  = id;
    rs_ready      = rsr;
    flush         = fl;
  endtask

  // Called just after a falling edge: checks outputs, advances one clock,
  // and moves the model across that edge.
  task automatic checkOutput(input string tag);
    bit   exp_ready;
    bit   exp_disp;
    bit   accept;
    ent_t e;
    #1;
    exp_ready = (model_q.size() < DEPTH);
    exp_disp  = reset_n && model_q.size() > 0 && !rob_full && rs_ready && !flush;
    chk({tag, ".dec_ready"}, 32'(dec_ready), 32'(exp_ready));
    chk({tag, ".rob_dispatch_en"}, 32'(rob_dispatch_en), 32'(exp_disp));
    chk({tag, ".rs_valid"}, 32'(rs_valid), 32'(exp_disp));
    chk({tag, ".rs_rob_id"}, 32'(rs_rob_id), 32'(rob_alloc_id));
    if (exp_disp) begin
      chk({tag, ".rs_payload"}, rs_payload, model_q[0].payload);
      chk({tag, ".rs_is_branch"}, 32'(rs_is_branch), 32'(model_q[0].is_branch));
    end
    chk({tag, ".stall_count"}, 32'(stall_count), model_stall);
    accept = dec_valid && exp_ready && !flush;
    @(posedge clk);
    if (reset_n) begin
      if (flush) begin
        model_q.delete();
      end else begin
        if (model_q.size() > 0 && !exp_disp) begin
          model_stall = (model_stall >= 32'hFFFF) ? 32'hFFFF : model_stall + 1;
        end
        if (exp_disp) begin
          void'(model_q.pop_front());
        end
        if (accept) begin
          e.payload   = dec_payload;
          e.is_branch = dec_is_branch;
          model_q.push_back(e);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    reset_n = 1'b0;
    model_q.delete();
    model_stall = 0;
    #1;
    chk("reset.rs_payload", rs_payload, 32'h0);
    chk("reset.rs_is_branch", 32'(rs_is_branch), 32'h0);
    checkOutput("reset");
    reset_n = 1'b1;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    model_stall = 0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    reset_n = 1'b0;
    @(negedge clk);
    doReset();

    // Three back-to-back instructions, ROB ids 0,1,2 granted in order.
    applyStimulus(1'b1, 32'hA000_0001, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    checkOutput("b2b0");
    applyStimulus(1'b1, 32'hA000_0002, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
    checkOutput("b2b1");
    applyStimulus(1'b1, 32'hA000_0003, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0);
    checkOutput("b2b2");
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0);
    checkOutput("b2b3");
    checkOutput("b2b4");

    // ROB full: two accepted, third refused, then drained in order.
    doReset();
    applyStimulus(1'b1, 32'hB000_0001, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0);
    checkOutput("robfull0");
    applyStimulus(1'b1, 32'hB000_0002, 1'b0, 1'b1, 4'd5, 1'b1, 1'b0);
    checkOutput("robfull1");
    applyStimulus(1'b1, 32'hB000_0003, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) checkOutput("robfull2");
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'd6, 1'b1, 1'b0);
    checkOutput("drain0");
    rob_alloc_id = 4'd7;
    checkOutput("drain1");
    checkOutput("drain2");

    // RS not ready with a single entry: strobes stay low together.
    doReset();
    applyStimulus(1'b1, 32'hC000_0001, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0);
    checkOutput("rsblk0");
    dec_valid = 1'b0;
    for (int i = 0; i < 5; i++) checkOutput("rsblk");
    chk("rsblk.stall_abs", 32'(stall_count), 32'd5);
    rs_ready = 1'b1;
    checkOutput("rsrel");

    // Flush a FULL buffer while decode is offering.
    applyStimulus(1'b1, 32'hD000_0001, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
    checkOutput("fill0");
    dec_payload = 32'hD000_0002;
    checkOutput("fill1");
    applyStimulus(1'b1, 32'hD000_0003, 1'b1, 1'b0, 4'd9, 1'b1, 1'b1);
    checkOutput("flush");
    applyStimulus(1'b1, 32'hE000_0001, 1'b1, 1'b0, 4'd10, 1'b1, 1'b0);
    checkOutput("postflush0");
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'd11, 1'b1, 1'b0);
    checkOutput("postflush1");
    checkOutput("postflush2");

    // Asynchronous reset mid-stream with two entries buffered.
    applyStimulus(1'b1, 32'hF000_0001, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
    checkOutput("prerst0");
    dec_payload = 32'hF000_0002;
    checkOutput("prerst1");
    #2;
    rob_full = 1'b0;
    dec_valid = 1'b0;
    reset_n = 1'b0;
    model_q.delete();
    model_stall = 0;
    #1;
    chk("asyncrst.rs_valid", 32'(rs_valid), 32'h0);
    chk("asyncrst.rob_dispatch_en", 32'(rob_dispatch_en), 32'h0);
    chk("asyncrst.dec_ready", 32'(dec_ready), 32'h1);
    @(negedge clk);
    reset_n = 1'b1;
    checkOutput("postrst0");
    checkOutput("postrst1");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom),
                    1'($urandom_range(0, 3) == 0), 4'($urandom),
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
      checkOutput("rand");
    end

    // Saturate the stall counter with the head blocked by the ROB.
    doReset();
    applyStimulus(1'b1, 32'h5A5A_0001, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0);
    checkOutput("sat0");
    dec_valid = 1'b0;
    for (int i = 0; i < 65540; i++) checkOutput("sat");
    chk("sat.hold", 32'(stall_count), 32'h0000_FFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dispatch_stage.md
# dispatch_stage

In-order dispatch buffer between decode and the ROB / reservation stations. It accepts decoded instructions over a valid/ready handshake and holds them in a small FIFO. For the oldest entry it allocates one ROB entry and issues one reservation-station write in the same cycle, tagging the RS write with the ROB index granted. On a branch mispredict it discards all buffered instructions.

## Interface
Parameters:
- ROB_IDX_W, 4, width of ROB index (matches ROB DEPTH=16; tests use 4-deep ROB with same width)
- PAYLOAD_W, 32, width of decoded-instruction payload
- BUF_DEPTH, 2, dispatch FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  system clock; single clock domain
- reset_n  in  1  asynchronous, active-low reset
- dec_valid  in  1  decode has an instruction
- dec_ready  out  1  buffer can accept
- dec_payload  in  PAYLOAD_W  decoded instruction
- dec_is_branch  in  1  instruction is a branch
- rob_full  in  1  ROB cannot allocate this cycle
- rob_alloc_id  in  ROB_IDX_W  index ROB assigns on dispatch_en
- rob_dispatch_en  out  1  allocate ROB entry this cycle
- rs_ready  in  1  RS has a free slot
- rs_valid  out  1  RS write strobe
- rs_payload  out  PAYLOAD_W  head payload
- rs_is_branch  out  1  head branch flag
- rs_rob_id  out  ROB_IDX_W  ROB tag for the RS entry (= rob_alloc_id)
- flush  in  1  branch mispredict; drive from ROB branch_mispredict
- stall_count  out  16  saturating count of blocked-head cycles

## Operation
- FIFO states: EMPTY (count=0), PARTIAL (0<count<BUF_DEPTH), FULL (count=BUF_DEPTH). Registered head/tail pointers wrap modulo BUF_DEPTH.
- dec_ready = (count < BUF_DEPTH). Driven combinationally from registered count only; it does not depend on the same-cycle dispatch.
- Enqueue: dec_valid & dec_ready & ~flush. Payload and branch flag are written at tail; tail advances.
- Dispatch condition: count>0 & ~rob_full & rs_ready & ~flush.
  - When it holds, rob_dispatch_en=1 and rs_valid=1 in the same cycle, and rs_rob_id=rob_alloc_id.
  - Head advances at the edge.
  - rob_dispatch_en and rs_valid are always equal.
- rs_payload/rs_is_branch always show the head slot; they are meaningful only when rs_valid=1.
- Simultaneous enqueue and dispatch: count unchanged, both pointers advance.
- In FULL, dec_ready=0, so there is no enqueue even if the head dispatches that cycle. There is no bypass.
- Flush:
  - Suppresses dispatch and enqueue in the flush cycle.
  - At the edge, count=0 and head=tail=0.
  - dec_ready=1 the following cycle.
  - Flush takes precedence over all other events.
- stall_count increments when count>0 & ~flush & ~dispatch. It saturates at 16'hFFFF and is not cleared by flush.
- Order is preserved: dispatch order equals accept order.

## Timing
- Reset (asynchronous assert, synchronous release): count=0, pointers=0, storage=0, stall_count=0. Outputs: dec_ready=1, rob_dispatch_en=0, rs_valid=0, rs_payload=0, rs_is_branch=0, rs_rob_id follows input.
- Latency: an instruction accepted at edge N can dispatch in the cycle after edge N at the earliest. Minimum is 1 cycle decode→RS.
- Throughput: 1 instruction/cycle sustained when ROB and RS are never blocked.
- Reset asserted mid-operation drops buffered entries immediately. No ROB allocation is issued for them.
- rob_full and rs_ready are sampled combinationally in the dispatch cycle, with no registered lookahead.

## Structure
- common_pkg:
  - ROB_IDX_W, PAYLOAD_W constants.
  - dispatch_entry_t struct {payload, is_branch}.
  - dispatch_state_e {EMPTY, PARTIAL, FULL}.
- Sub-module dispatch_fifo: parameterised storage, pointers and count, with push/pop/clear, full/empty and head data.
- dispatch_stage wraps dispatch_fifo and contains the dispatch condition, flush gating and stall counter.

## Test plan
- Reset, then 3 back-to-back dec_valid with ROB/RS free and rob_alloc_id 0,1,2 → rs_valid on 3 consecutive cycles starting 1 cycle after the first accept; rs_rob_id=0,1,2; dec_ready stays 1.
- rob_full=1 and 3 instructions offered → 2 accepted, then dec_ready=0. stall_count increments each cycle. Release rob_full → dispatch in accept order.
- rs_ready=0 with count=1 → rs_valid=0 and rob_dispatch_en=0 in the same cycles (never split); stall_count=N after N cycles.
- FULL buffer, flush=1 for one cycle while dec_valid=1 → no dispatch and no enqueue that cycle. Next cycle count=0 and dec_ready=1; later dispatch shows only new instructions.
- Force stall_count to saturation (65540 blocked cycles) → holds 16'hFFFF.
- Assert reset_n=0 asynchronously mid-stream with count=2 → rs_valid=0 immediately. After release, dec_ready=1 and no stale dispatch.
